receptor_uart: RTL

RECEPTOR_UART -- requirements
Module: receptor_uart

---
 rtl/receptor_uart.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/receptor_uart.sv
// UART receiver: 2-flop synchronized rx, mid-bit sampling, sticky error flags, arbiter clear.
// Define RECEPTOR_PARIDADE_EN for 8E1 frames (even parity); default build receives 8N1.
module receptor_uart #(
    parameter int unsigned CLKS_POR_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic       reseta,
    output logic [7:0] dado,
    output logic       readyRx,
    output logic       busyRx,
    output logic       erroFrame,
    output logic       overrun,
    output logic       erroParidade
);
    localparam logic [15:0] CNT_HALF = 16'(CLKS_POR_BIT / 2 - 1);
    localparam logic [15:0] CNT_FULL = 16'(CLKS_POR_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARIDADE, STOP} state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        rx_meta_q, rx_sync_q;
    logic        done_q, stop_ok_q;
    logic [7:0]  dado_q;
    logic        ready_q, busy_q, erro_frame_q, overrun_q;
`ifdef RECEPTOR_PARIDADE_EN
    logic        par_bad_q, erro_par_q;
`endif

    assign cnt_d = cnt_q + 16'd1;

    // The stop sample only records the verdict; dado/readyRx are committed one edge later
    // (done_q), which is also where a simultaneous reseta is overridden by the new byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            done_q       <= 1'b0;
            stop_ok_q    <= 1'b0;
            dado_q       <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            erro_frame_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
            par_bad_q    <= 1'b0;
            erro_par_q   <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            done_q    <= 1'b0;

            if (reseta) begin
                ready_q      <= 1'b0;
                erro_frame_q <= 1'b0;
                overrun_q    <= 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
                erro_par_q   <= 1'b0;
`endif
            end

            if (done_q) begin
                if (!stop_ok_q) begin
                    erro_frame_q <= 1'b1;
`ifdef RECEPTOR_PARIDADE_EN
                end else if (par_bad_q) begin
                    erro_par_q <= 1'b1;
`endif
                end else if (ready_q && !reseta) begin
                    overrun_q <= 1'b1;
                end else begin
                    dado_q  <= shift_q;
                    ready_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (!rx_sync_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (!rx_sync_q) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
`ifdef RECEPTOR_PARIDADE_EN
                            state_q <= PARIDADE;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                PARIDADE: begin
`ifdef RECEPTOR_PARIDADE_EN
                    if (cnt_q == CNT_FULL) begin
                        cnt_q     <= '0;
                        par_bad_q <= rx_sync_q ^ (^shift_q);
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
`else
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`endif
                end
                STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q     <= '0;
                        stop_ok_q <= rx_sync_q;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dado      = dado_q;
    assign readyRx   = ready_q;
    assign busyRx    = busy_q;
    assign erroFrame = erro_frame_q;
    assign overrun   = overrun_q;
`ifdef RECEPTOR_PARIDADE_EN
    assign erroParidade = erro_par_q;
`else
    assign erroParidade = 1'b0;
`endif
endmodule
